// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset vector, NOP encoding, fetch FSM
// state encoding and the opcode constants the control unit also decodes.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // Fetch FSM: StKill means a squashed request is still outstanding on the bus.
    typedef enum logic [0:0] {
        StFetch = 1'b0,
        StKill  = 1'b1
    } fetch_state_e;

    // Primary opcodes shared with the control unit.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic [5:0] get_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] get_funct(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched {instr, pc} that arrived while the
// IF/ID slot was stalled. Clear has priority over load so a redirect always
// empties it.
module fetch_skid_buf
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              drain,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              full,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc
);

    logic              full_q;
    logic [31:0]       instr_q;
    logic [ADDR_W-1:0] pc_q;

    // Entry register with full flag; data only captured on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (clear) begin
            full_q  <= 1'b0;
        end else if (load) begin
            full_q  <= 1'b1;
            instr_q <= load_instr;
            pc_q    <= load_pc;
        end else if (drain) begin
            full_q  <= 1'b0;
        end
    end

    assign full  = full_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a req/ready
// handshake, and presents a registered IF/ID slot to decode. Stalls spill one
// extra instruction into a skid buffer; redirects flush and squash in-flight
// fetches via the StKill state.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc_plus4,
    output logic [5:0]        opcode,
    output logic [5:0]        funct
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;

    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [ADDR_W-1:0] if_pc_plus4_q, if_pc_plus4_d;

    logic              skid_full;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc;
    logic              skid_load, skid_drain, skid_clear;

    logic              accept;
    logic [ADDR_W-1:0] redirect_target;
    logic              unused_redirect_lsb;

    assign redirect_target     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .clear      (skid_clear),
        .load       (skid_load),
        .drain      (skid_drain),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .full       (skid_full),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // Bus request: held during reset low; in StKill replay the squashed address.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        unique case (state_q)
            StFetch: imem_req = !rst && !skid_full;
            StKill: begin
                imem_req  = !rst;
                imem_addr = kill_addr_q;
            end
            default: imem_req = 1'b0;
        endcase
    end

    // A redirect in the same cycle as ready drops the returned word.
    assign accept = imem_req && imem_ready && (state_q == StFetch) && !redirect_valid;

    // Next-state for FSM, PC, IF/ID slot and skid control.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_addr_d   = kill_addr_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        skid_load     = 1'b0;
        skid_drain    = 1'b0;
        skid_clear    = 1'b0;

        if (redirect_valid) begin
            pc_d       = redirect_target;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            skid_clear = 1'b1;
            unique case (state_q)
                StFetch: begin
                    if (imem_req && !imem_ready) begin
                        state_d     = StKill;
                        kill_addr_d = pc_q;
                    end
                end
                StKill: begin
                    // The squashed request completes now; nothing left to drain.
                    if (imem_ready) begin
                        state_d = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end else begin
            if (state_q == StKill && imem_ready) begin
                state_d = StFetch;
            end

            if (accept) begin
                pc_d = pc_q + PC_STEP;
            end

            if (skid_full && !stall) begin
                if_valid_d    = 1'b1;
                if_instr_d    = skid_instr;
                if_pc_d       = skid_pc;
                if_pc_plus4_d = skid_pc + PC_STEP;
                skid_drain    = 1'b1;
            end else if (accept && (!if_valid_q || !stall)) begin
                if_valid_d    = 1'b1;
                if_instr_d    = imem_rdata;
                if_pc_d       = pc_q;
                if_pc_plus4_d = pc_q + PC_STEP;
            end else if (accept) begin
                skid_load = 1'b1;
            end else if (!stall && if_valid_q) begin
                // Slot consumed with nothing to replace it: go to NOP.
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            kill_addr_q   <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= NOP_INSTR;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_addr_q   <= kill_addr_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;
    assign opcode      = get_opcode(if_instr_q);
    assign funct       = get_funct(if_instr_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Memory returns 0x8C0A0004 ^ addr[15:0]
// combinationally; inputs change 1ns after posedge, outputs sampled on negedge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'h8C0A_0004 ^ {16'h0000, imem_addr[15:0]};

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .opcode         (opcode),
        .funct          (funct)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ready     = 1'b1;

        // Reset state
        step();
        @(negedge clk);
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_valid", if_valid, 0);
        check_eq("rst_instr", if_instr, 0);
        check_eq("rst_pc", if_pc, 0);
        check_eq("rst_pc4", if_pc_plus4, 0);

        // Streaming, zero-wait
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("s0_req", imem_req, 1);
        check_eq("s0_addr", imem_addr, 32'h0);
        check_eq("s0_valid", if_valid, 0);
        step();
        @(negedge clk);
        check_eq("s1_addr", imem_addr, 32'h4);
        check_eq("s1_valid", if_valid, 1);
        check_eq("s1_pc", if_pc, 32'h0);
        check_eq("s1_instr", if_instr, 32'h8C0A_0004);
        check_eq("s1_opcode", opcode, 6'h23);
        check_eq("s1_funct", funct, 6'h04);
        check_eq("s1_pc4", if_pc_plus4, 32'h4);
        step();
        @(negedge clk);
        check_eq("s2_addr", imem_addr, 32'h8);
        check_eq("s2_pc", if_pc, 32'h4);

        // Stall into skid while slot holds PC 0x8
        step();
        stall = 1'b1;
        @(negedge clk);
        check_eq("st0_req", imem_req, 1);
        check_eq("st0_addr", imem_addr, 32'hC);
        check_eq("st0_pc", if_pc, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check_eq("st_req_off", imem_req, 0);
            check_eq("st_pc_hold", if_pc, 32'h8);
            check_eq("st_instr_hold", if_instr, 32'h8C0A_000C);
            check_eq("st_valid_hold", if_valid, 1);
        end
        step();
        stall = 1'b0;
        @(negedge clk);
        check_eq("dr_req", imem_req, 0);
        check_eq("dr_pc", if_pc, 32'h8);

        // Skid drained; fetch resumes at 0x10 which then sees 3 wait states
        step();
        imem_ready = 1'b0;
        @(negedge clk);
        check_eq("dr1_pc", if_pc, 32'hC);
        check_eq("w0_req", imem_req, 1);
        check_eq("w0_addr", imem_addr, 32'h10);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) imem_ready = 1'b1;
            @(negedge clk);
            check_eq("w_req", imem_req, 1);
            check_eq("w_addr", imem_addr, 32'h10);
            check_eq("w_valid", if_valid, 0);
        end
        step();
        @(negedge clk);
        check_eq("w4_valid", if_valid, 1);
        check_eq("w4_pc", if_pc, 32'h10);
        check_eq("w4_instr", if_instr, 32'h8C0A_0014);
        check_eq("w4_addr", imem_addr, 32'h14);

        // Redirect while request at 0x20 is waiting
        step();
        step();
        step();
        imem_ready = 1'b0;
        @(negedge clk);
        check_eq("rw0_addr", imem_addr, 32'h20);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        check_eq("rw1_addr", imem_addr, 32'h20);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("rw2_valid", if_valid, 0);
        check_eq("rw2_req", imem_req, 1);
        check_eq("rw2_addr", imem_addr, 32'h20);
        check_eq("rw2_opcode", opcode, 0);
        step();
        imem_ready = 1'b1;
        @(negedge clk);
        check_eq("rw3_addr", imem_addr, 32'h20);
        step();
        @(negedge clk);
        check_eq("rw4_addr", imem_addr, 32'h100);
        check_eq("rw4_valid", if_valid, 0);
        check_eq("rw4_instr", if_instr, 0);

        // Redirect with same-cycle ready and stall
        step();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        check_eq("rs0_pc", if_pc, 32'h100);
        check_eq("rs0_addr", imem_addr, 32'h104);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("rs1_addr", imem_addr, 32'h200);
        check_eq("rs1_req", imem_req, 1);
        check_eq("rs1_valid", if_valid, 0);
        check_eq("rs1_opcode", opcode, 0);
        check_eq("rs1_funct", funct, 0);
        step();
        @(negedge clk);
        check_eq("rs2_valid", if_valid, 1);
        check_eq("rs2_pc", if_pc, 32'h200);
        check_eq("rs2_instr", if_instr, 32'h8C0A_0204);
        check_eq("rs2_addr", imem_addr, 32'h204);
        step();
        stall = 1'b0;
        @(negedge clk);
        check_eq("rs3_req", imem_req, 0);
        check_eq("rs3_pc", if_pc, 32'h200);

        // Wrap at top of address space (low bits of target ignored)
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        @(negedge clk);
        check_eq("wr0_pc", if_pc, 32'h204);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("wr1_addr", imem_addr, 32'hFFFF_FFFC);
        check_eq("wr1_req", imem_req, 1);
        check_eq("wr1_valid", if_valid, 0);
        step();
        @(negedge clk);
        check_eq("wr2_pc", if_pc, 32'hFFFF_FFFC);
        check_eq("wr2_pc4", if_pc_plus4, 32'h0);
        check_eq("wr2_addr", imem_addr, 32'h0);
        check_eq("wr2_instr", if_instr, 32'h8C0A_FFF8);
        check_eq("wr2_funct", funct, 6'h38);

        // Reset mid-stream
        step();
        rst = 1'b1;
        @(negedge clk);
        check_eq("mr0_req", imem_req, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("mr1_valid", if_valid, 0);
        check_eq("mr1_pc", if_pc, 32'h0);
        check_eq("mr1_addr", imem_addr, 32'h0);
        check_eq("mr1_req", imem_req, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
